// File: rtl/operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : operand_stack
//  Description : Registered LIFO operand stack with PUSH/POP/DROP/DROPN/CLEAR
//                commands and a sticky trap register. The DROPN command is
//                available only when OPERAND_STACK_DROPN_EN is defined;
//                otherwise op 4 is reserved and raises an illegal-op trap.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_stack #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   op,
  input  logic [WIDTH-1:0]             din,
  input  logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         empty,
  output logic                         full,
  output logic [2:0]                   trap
);

  localparam int C_DW = $clog2(DEPTH + 1);
  localparam int C_AW = $clog2(DEPTH);

  localparam logic [2:0] C_OP_NOP   = 3'd0;
  localparam logic [2:0] C_OP_PUSH  = 3'd1;
  localparam logic [2:0] C_OP_POP   = 3'd2;
  localparam logic [2:0] C_OP_DROP  = 3'd3;
  localparam logic [2:0] C_OP_DROPN = 3'd4;
  localparam logic [2:0] C_OP_CLEAR = 3'd5;

  localparam logic [2:0] C_TRAP_NONE = 3'd0;
  localparam logic [2:0] C_TRAP_OVF  = 3'd1;
  localparam logic [2:0] C_TRAP_UDF  = 3'd2;
  localparam logic [2:0] C_TRAP_ILL  = 3'd3;

  // Entry storage: never reset, only slots below depth are ever observed.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [C_DW-1:0]  depth_q, depth_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [2:0]       trap_q, trap_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  logic             wr_en;
  logic [C_AW-1:0]  wr_idx;
  logic [C_AW-1:0]  rd_idx;
  logic [C_DW-1:0]  new_depth;
  logic             shrink;

`ifndef OPERAND_STACK_DROPN_EN
  // count only matters for DROPN, which is absent in this build.
  logic unused_count;
  assign unused_count = ^count;
`endif

  // Command decode: next depth/top/dout/trap; shrinking ops re-expose entry depth-1.
  always_comb begin
    depth_d      = depth_q;
    top_d        = top_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    trap_d       = trap_q;
    wr_en        = 1'b0;
    wr_idx       = C_AW'(depth_q);
    new_depth    = depth_q;
    shrink       = 1'b0;
    rd_idx       = '0;

    if (trap_q == C_TRAP_NONE) begin
      case (op)
        C_OP_NOP: ;
        C_OP_PUSH: begin
          if (full_q) begin
            trap_d = C_TRAP_OVF;
          end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + C_DW'(1);
            top_d   = din;
          end
        end
        C_OP_POP: begin
          if (empty_q) begin
            trap_d = C_TRAP_UDF;
          end else begin
            dout_d       = top_q;
            dout_valid_d = 1'b1;
            new_depth    = depth_q - C_DW'(1);
            shrink       = 1'b1;
          end
        end
        C_OP_DROP: begin
          if (empty_q) begin
            trap_d = C_TRAP_UDF;
          end else begin
            new_depth = depth_q - C_DW'(1);
            shrink    = 1'b1;
          end
        end
`ifdef OPERAND_STACK_DROPN_EN
        C_OP_DROPN: begin
          if (count > depth_q) begin
            trap_d = C_TRAP_UDF;
          end else if (count != '0) begin
            new_depth = depth_q - count;
            shrink    = 1'b1;
          end
        end
`endif
        C_OP_CLEAR: begin
          depth_d = '0;
          top_d   = '0;
        end
        default: trap_d = C_TRAP_ILL;
      endcase
    end

    if (shrink) begin
      depth_d = new_depth;
      rd_idx  = C_AW'(new_depth - C_DW'(1));
      top_d   = (new_depth == '0) ? '0 : mem_q[rd_idx];
    end

    empty_d = (depth_d == '0);
    full_d  = (depth_d == C_DW'(DEPTH));
  end

  // Control/status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q      <= '0;
      top_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      trap_q       <= C_TRAP_NONE;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
    end else begin
      depth_q      <= depth_d;
      top_q        <= top_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      trap_q       <= trap_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
    end
  end

  // Entry write on accepted PUSH; reset wins, so no write during reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign top        = top_q;
  assign depth      = depth_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign trap       = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_stack
//  Description : Directed self-checking bench for operand_stack (DEPTH=4).
//                DROPN vectors are selected by OPERAND_STACK_DROPN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stack;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [DW-1:0]    count;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [WIDTH-1:0] top;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic [2:0]       trap;

  int n_vec  = 0;
  int n_miss = 0;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .op(op), .din(din), .count(count),
    .dout(dout), .dout_valid(dout_valid), .top(top), .depth(depth),
    .empty(empty), .full(full), .trap(trap)
  );

  always #5 clk = ~clk;

  // Apply one command for one edge, then settle 1ns past the edge.
  task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic [DW-1:0] c);
    op = o; din = d; count = c;
    @(posedge clk); #1;
    op = 3'd0; din = '0; count = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 3'd1; din = 64'hDEAD; count = '0;
    @(posedge clk); #1;   // PUSH asserted with reset: reset must win
    reset = 1'b0; op = 3'd0;
    n_vec++; if (depth !== 3'd0) begin n_miss++; $display("FAIL reset_depth: got %0d want 0", depth); end
    n_vec++; if (top !== 64'd0) begin n_miss++; $display("FAIL reset_top: got %h want 0", top); end
    n_vec++; if (dout !== 64'd0 || dout_valid !== 1'b0) begin n_miss++; $display("FAIL reset_dout: got %h/%b want 0/0", dout, dout_valid); end
    n_vec++; if (trap !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_miss++; $display("FAIL reset_flags: got trap=%0d empty=%b full=%b want 0/1/0", trap, empty, full); end
  endtask

  task automatic test_push();
    step(3'd1, 64'hA, '0);
    step(3'd1, 64'hB, '0);
    step(3'd1, 64'hC, '0);
    n_vec++; if (depth !== 3'd3) begin n_miss++; $display("FAIL push_depth: got %0d want 3", depth); end
    n_vec++; if (top !== 64'hC) begin n_miss++; $display("FAIL push_top: got %h want c", top); end
    n_vec++; if (empty !== 1'b0 || full !== 1'b0 || trap !== 3'd0) begin n_miss++; $display("FAIL push_flags: got empty=%b full=%b trap=%0d want 0/0/0", empty, full, trap); end
  endtask

  task automatic test_pop_drop();
    step(3'd2, '0, '0);
    n_vec++; if (dout !== 64'hC || dout_valid !== 1'b1) begin n_miss++; $display("FAIL pop_dout: got %h/%b want c/1", dout, dout_valid); end
    n_vec++; if (depth !== 3'd2 || top !== 64'hB) begin n_miss++; $display("FAIL pop_state: got depth=%0d top=%h want 2/b", depth, top); end
    step(3'd3, '0, '0);
    n_vec++; if (depth !== 3'd1 || top !== 64'hA) begin n_miss++; $display("FAIL drop_state: got depth=%0d top=%h want 1/a", depth, top); end
    n_vec++; if (dout_valid !== 1'b0 || dout !== 64'hC) begin n_miss++; $display("FAIL drop_dout: got %h/%b want c/0", dout, dout_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) step(3'd1, 64'(i), '0);
    n_vec++; if (full !== 1'b1 || depth !== 3'd4 || top !== 64'd4) begin n_miss++; $display("FAIL fill: got full=%b depth=%0d top=%h want 1/4/4", full, depth, top); end
    step(3'd1, 64'h5, '0);
    n_vec++; if (trap !== 3'd1 || top !== 64'd4 || depth !== 3'd4) begin n_miss++; $display("FAIL ovf: got trap=%0d top=%h depth=%0d want 1/4/4", trap, top, depth); end
    step(3'd2, '0, '0);
    n_vec++; if (dout_valid !== 1'b0 || depth !== 3'd4 || trap !== 3'd1) begin n_miss++; $display("FAIL ovf_pop_ignored: got dv=%b depth=%0d trap=%0d want 0/4/1", dout_valid, depth, trap); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(3'd3, '0, '0);
    n_vec++; if (trap !== 3'd2 || empty !== 1'b1) begin n_miss++; $display("FAIL udf_drop: got trap=%0d empty=%b want 2/1", trap, empty); end
    step(3'd5, '0, '0);
    step(3'd1, 64'h9, '0);
    n_vec++; if (trap !== 3'd2 || depth !== 3'd0) begin n_miss++; $display("FAIL udf_sticky: got trap=%0d depth=%0d want 2/0", trap, depth); end
    do_reset();
    n_vec++; if (trap !== 3'd0) begin n_miss++; $display("FAIL udf_reset: got trap=%0d want 0", trap); end
  endtask

`ifdef OPERAND_STACK_DROPN_EN
  task automatic test_dropn();
    do_reset();
    for (int i = 1; i <= 4; i++) step(3'd1, 64'(i), '0);
    step(3'd4, '0, 3'd3);
    n_vec++; if (depth !== 3'd1 || top !== 64'd1 || trap !== 3'd0) begin n_miss++; $display("FAIL dropn3: got depth=%0d top=%h trap=%0d want 1/1/0", depth, top, trap); end
    step(3'd4, '0, 3'd0);
    n_vec++; if (depth !== 3'd1 || top !== 64'd1 || trap !== 3'd0) begin n_miss++; $display("FAIL dropn0: got depth=%0d top=%h trap=%0d want 1/1/0", depth, top, trap); end
    step(3'd4, '0, 3'd2);
    n_vec++; if (trap !== 3'd2 || depth !== 3'd1 || top !== 64'd1) begin n_miss++; $display("FAIL dropn_udf: got trap=%0d depth=%0d top=%h want 2/1/1", trap, depth, top); end
    do_reset();
    step(3'd1, 64'h11, '0);
    step(3'd1, 64'h22, '0);
    step(3'd4, '0, 3'd2);
    n_vec++; if (depth !== 3'd0 || top !== 64'd0 || empty !== 1'b1) begin n_miss++; $display("FAIL dropn_all: got depth=%0d top=%h empty=%b want 0/0/1", depth, top, empty); end
  endtask
`else
  task automatic test_dropn();
    do_reset();
    step(3'd1, 64'h7, '0);
    step(3'd4, '0, 3'd1);
    n_vec++; if (trap !== 3'd3 || depth !== 3'd1 || top !== 64'h7) begin n_miss++; $display("FAIL op4_reserved: got trap=%0d depth=%0d top=%h want 3/1/7", trap, depth, top); end
  endtask
`endif

  task automatic test_clear_illegal();
    do_reset();
    step(3'd1, 64'h33, '0);
    step(3'd1, 64'h44, '0);
    step(3'd5, '0, '0);
    n_vec++; if (depth !== 3'd0 || top !== 64'd0 || trap !== 3'd0 || empty !== 1'b1) begin n_miss++; $display("FAIL clear: got depth=%0d top=%h trap=%0d empty=%b want 0/0/0/1", depth, top, trap, empty); end
    step(3'd1, 64'h55, '0);
    step(3'd6, '0, '0);
    n_vec++; if (trap !== 3'd3 || depth !== 3'd1 || top !== 64'h55) begin n_miss++; $display("FAIL illegal6: got trap=%0d depth=%0d top=%h want 3/1/55", trap, depth, top); end
    do_reset();
    step(3'd7, '0, '0);
    n_vec++; if (trap !== 3'd3) begin n_miss++; $display("FAIL illegal7: got trap=%0d want 3", trap); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(3'd1, 64'h100, '0);
    step(3'd1, 64'h200, '0);
    step(3'd2, '0, '0);
    n_vec++; if (dout !== 64'h200 || dout_valid !== 1'b1 || top !== 64'h100) begin n_miss++; $display("FAIL b2b_pop1: got dout=%h dv=%b top=%h want 200/1/100", dout, dout_valid, top); end
    step(3'd1, 64'h300, '0);
    n_vec++; if (dout_valid !== 1'b0 || top !== 64'h300 || depth !== 3'd2) begin n_miss++; $display("FAIL b2b_push: got dv=%b top=%h depth=%0d want 0/300/2", dout_valid, top, depth); end
    step(3'd2, '0, '0);
    step(3'd2, '0, '0);
    n_vec++; if (dout !== 64'h100 || dout_valid !== 1'b1 || empty !== 1'b1 || top !== 64'd0) begin n_miss++; $display("FAIL b2b_pop2: got dout=%h dv=%b empty=%b top=%h want 100/1/1/0", dout, dout_valid, empty, top); end
    step(3'd0, '0, '0);
    n_vec++; if (dout_valid !== 1'b0 || dout !== 64'h100) begin n_miss++; $display("FAIL b2b_nop: got dout=%h dv=%b want 100/0", dout, dout_valid); end
  endtask

  initial begin
    reset = 1'b0; op = '0; din = '0; count = '0;
    @(negedge clk);
    test_reset();
    test_push();
    test_pop_drop();
    test_overflow();
    test_underflow();
    test_dropn();
    test_clear_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
